// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, drives the word address into a
// combinational instruction memory, and registers each fetched word into a one-entry slot
// offered to decode over a valid/ready handshake. Handles stalls, redirects and halt words.
// Optional macro FETCH_BOUNDS_CHECK_EN: out-of-range fetches raise a sticky fetch_fault and
// halt, instead of wrapping the fetch address modulo the memory depth.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        fault_q, fault_d;

  logic transfer, slot_free, out_of_range, can_resume;

  assign transfer  = inst_valid_q & inst_ready;
  assign slot_free = ~inst_valid_q | inst_ready;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign out_of_range = (pc_q[31:IMEM_AW+2] != '0);
  assign can_resume   = ~fault_q;
`else
  assign out_of_range = 1'b0;
  assign can_resume   = 1'b1;
`endif

  // Next-state: handshake drain, then per-state fetch control (redirect beats capture/halt).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    fault_d       = fault_q;

    if (transfer) begin
      inst_valid_d  = 1'b0;
      fetch_count_d = fetch_count_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_d         = {redirect_pc[31:2], 2'b00};
          inst_valid_d = 1'b0;
        end else if (slot_free) begin
          if (out_of_range) begin
            fault_d  = 1'b1;
            state_d  = StHalt;
            halted_d = 1'b1;
          end else if (imem_data == HALT_WORD) begin
            // Halt word is never issued; pc stays on it so resume continues past it.
            state_d  = StHalt;
            halted_d = 1'b1;
          end else begin
            inst_d       = imem_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      StHalt: begin
        if (start && can_resume) begin
          state_d  = StFetch;
          pc_d     = pc_q + 32'd4;
          halted_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'd0;
      inst_pc_q     <= 32'd0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'd0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a 4-word combinational instruction memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  logic [31:0] mem [4];
  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] W0 = 32'h2001_0005;
  localparam logic [31:0] W1 = 32'h2002_0007;
  localparam logic [31:0] W2 = 32'hFFFF_FFFF;
  localparam logic [31:0] W3 = 32'h2003_0009;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_flags: got %b%b want 00", halted, fetch_fault); end
    checks++; if (fetch_count !== 32'd0 || imem_addr !== 2'd0) begin fails++; $display("FAIL reset_count_addr: got %h/%0d want 0/0", fetch_count, imem_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  // Two words issued back to back, then the halt word stops fetch.
  task automatic test_fetch_halt();
    inst_ready = 1'b1;
    pulse_start();
    checks++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL latency_early: got %b want 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst !== W0 || inst_pc !== 32'h0) begin fails++; $display("FAIL first_inst: got %b %h @%h want 1 %h @0", inst_valid, inst, inst_pc, W0); end
    tick();
    checks++; if (inst !== W1 || inst_pc !== 32'h4 || fetch_count !== 32'd1) begin fails++; $display("FAIL second_inst: got %h @%h cnt %0d want %h @4 cnt 1", inst, inst_pc, fetch_count, W1); end
    tick();
    checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || fetch_count !== 32'd2 || imem_addr !== 2'd2) begin fails++; $display("FAIL halt: got h%b v%b cnt %0d a%0d want h1 v0 cnt 2 a2", halted, inst_valid, fetch_count, imem_addr); end
  endtask

  // Redirect is ignored in HALT; start resumes past the halt word.
  task automatic test_halt_resume();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b1 || imem_addr !== 2'd2 || inst_valid !== 1'b0) begin fails++; $display("FAIL halt_redirect: got h%b a%0d v%b want h1 a2 v0", halted, imem_addr, inst_valid); end
    inst_ready = 1'b0;
    pulse_start();
    checks++; if (halted !== 1'b0 || imem_addr !== 2'd3) begin fails++; $display("FAIL resume: got h%b a%0d want h0 a3", halted, imem_addr); end
    tick();
    checks++; if (inst !== W3 || inst_pc !== 32'hC || inst_valid !== 1'b1) begin fails++; $display("FAIL resume_inst: got %h @%h want %h @c", inst, inst_pc, W3); end
  endtask

  task automatic test_stall();
    apply_reset();
    inst_ready = 1'b0;
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst !== W0 || inst_pc !== 32'h0 || imem_addr !== 2'd1 || fetch_count !== 32'd0) begin fails++; $display("FAIL stall_%0d: got %h @%h a%0d cnt %0d want %h @0 a1 cnt 0", i, inst, inst_pc, imem_addr, fetch_count, W0); end
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (inst !== W1 || inst_pc !== 32'h4 || fetch_count !== 32'd1) begin fails++; $display("FAIL stall_release: got %h @%h cnt %0d want %h @4 cnt 1", inst, inst_pc, fetch_count, W1); end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0007;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 2'd1 || fetch_count !== 32'd1) begin fails++; $display("FAIL redirect_flush: got v%b a%0d cnt %0d want v0 a1 cnt 1", inst_valid, imem_addr, fetch_count); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst !== W1 || inst_pc !== 32'h4) begin fails++; $display("FAIL redirect_target: got v%b %h @%h want v1 %h @4", inst_valid, inst, inst_pc, W1); end
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_count !== 32'd2 || inst_valid !== 1'b0 || imem_addr !== 2'd0) begin fails++; $display("FAIL redirect_xfer: got cnt %0d v%b a%0d want cnt 2 v0 a0", fetch_count, inst_valid, imem_addr); end
    inst_ready = 1'b0;
    tick();
    checks++; if (inst !== W0 || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin fails++; $display("FAIL redirect_zero: got %h @%h want %h @0", inst, inst_pc, W0); end
  endtask

  task automatic test_reset_midstall();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || fetch_count !== 32'd0 || imem_addr !== 2'd0) begin fails++; $display("FAIL async_reset: got v%b %h @%h cnt %0d a%0d want all 0", inst_valid, inst, inst_pc, fetch_count, imem_addr); end
    #1 rst_n = 1'b1;
    tick();
    pulse_start();
    tick();
    checks++; if (inst !== W0 || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin fails++; $display("FAIL restart: got %h @%h want %h @0", inst, inst_pc, W0); end
  endtask

  task automatic test_bounds();
    apply_reset();
    inst_ready = 1'b1;
    pulse_start();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 2'd0) begin fails++; $display("FAIL bounds_redirect: got v%b a%0d want v0 a0", inst_valid, imem_addr); end
    tick();
`ifdef FETCH_BOUNDS_CHECK_EN
    checks++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0) begin fails++; $display("FAIL bounds_fault: got f%b h%b v%b want f1 h1 v0", fetch_fault, halted, inst_valid); end
    pulse_start();
    tick();
    checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || fetch_count !== 32'd0) begin fails++; $display("FAIL bounds_sticky: got h%b v%b cnt %0d want h1 v0 cnt 0", halted, inst_valid, fetch_count); end
`else
    checks++; if (inst_valid !== 1'b1 || inst !== W0 || inst_pc !== 32'h10 || fetch_fault !== 1'b0) begin fails++; $display("FAIL bounds_wrap: got v%b %h @%h f%b want v1 %h @10 f0", inst_valid, inst, inst_pc, fetch_fault, W0); end
`endif
  endtask

  initial begin
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
    test_reset();
    test_fetch_halt();
    test_halt_resume();
    test_stall();
    test_redirect();
    test_reset_midstall();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the word address into the combinational instruction memory.
- Registers each fetched word into a one-entry output slot and offers it to decode over a valid/ready handshake.
- Handles stalls, branch/jump redirects, and halt-word detection.
- Sits between the instruction memory and the decode/control path of the MIPS core.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after start.
- IMEM_AW, 2, instruction-memory word-address width (depth = 2**IMEM_AW).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins or resumes fetch.
- imem_addr  output  IMEM_AW  word index to instruction memory, equal to pc[IMEM_AW+1:2].
- imem_data  input  32  combinational read data for imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target byte address; bits [1:0] are ignored and treated as 00.
- inst_valid  output  1  output slot holds an instruction.
- inst_ready  input  1  decode accepts the slot.
- inst  output  32  instruction word.
- inst_pc  output  32  byte address of inst.
- halted  output  1  sequencer is in HALT.
- fetch_count  output  32  count of instructions handed to decode.
- fetch_fault  output  1  out-of-range fetch (see optional feature).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC, state=IDLE.
  - inst_valid=0, inst=0, inst_pc=0, halted=0, fetch_count=0, fetch_fault=0.
  - Reset mid-fetch discards the slot contents.
- States: IDLE, FETCH, HALT.
  - IDLE: no capture, no pc change. start -> FETCH at the next edge with pc unchanged. redirect_valid is ignored.
  - FETCH: imem_addr is driven from the pc register every cycle.
    - The slot is free when inst_valid=0 or (inst_valid & inst_ready).
    - Free slot, word != HALT_WORD, no redirect: inst<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (modulo 2^32).
    - Free slot and word == HALT_WORD: the halt word is not issued. Slot empties if it was being accepted. pc holds at the halt address; state -> HALT; halted<=1.
    - Slot occupied and not accepted (stall): inst, inst_pc and pc hold, and imem_data is not sampled.
  - HALT: no capture, and redirect_valid is ignored. Any instruction already in the slot still drains normally. start -> FETCH with pc<=pc+4 and halted<=0.
- Redirect (FETCH only) has priority over capture and halt detection:
  - pc<={redirect_pc[31:2],2'b00} and inst_valid<=0 (flushes the slot). No word is captured that cycle.
  - First target instruction appears in the slot 1 cycle after the redirect edge (redirect-to-valid latency = 2 edges).
- Handshake:
  - Transfer occurs on an edge where inst_valid & inst_ready.
  - inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
  - Back-to-back transfers every cycle when inst_ready is held high (throughput 1/cycle).
- fetch_count:
  - Increments by 1 on every transfer edge, including a transfer coincident with a redirect.
  - Wraps 32'hFFFF_FFFF -> 0.
- start while in FETCH is ignored.
- Fetch latency: the first instruction is valid on the 2nd rising edge after the start pulse is sampled.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In FETCH with a free slot and no redirect, if pc[31:IMEM_AW+2] != 0: no capture, fetch_fault<=1 (sticky until reset), state -> HALT, halted<=1.
  - start does not leave HALT while fetch_fault=1.
- Undefined:
  - The upper pc bits are dropped, so the fetch address wraps modulo the memory depth.
  - fetch_fault is tied to 0.

Test Plan:
- Memory {0x2001_0005, 0x2002_0007, 0xFFFF_FFFF}, start, inst_ready=1 -> inst 0x20010005 @ pc 0 then 0x20020007 @ pc 4; halted=1, fetch_count=2, inst_valid=0 afterwards.
- inst_ready=0 for 3 cycles after first valid -> inst/inst_pc held at 0x20010005/0; pc stays 4; imem_addr=1 throughout; release gives next word the cycle after acceptance.
- redirect_valid with redirect_pc=0x0000_0007 while slot holds pc 4 -> slot flushed, next inst_pc=0x4, fetch_count unchanged unless a transfer coincided.
- Assert rst_n=0 mid-stall with inst_valid=1 -> all outputs zero immediately without a clock edge; start resumes from RESET_PC.
- HALT then start -> fetch resumes at halt address+4 with halted=0; redirect during HALT has no effect.
- With FETCH_BOUNDS_CHECK_EN, IMEM_AW=2, redirect to 0x10 -> fetch_fault=1, halted=1, no instruction issued. Without the macro, the same redirect fetches word 0.
